// File: rtl/v_hier_sched_if.sv
// ============================================================================
// Module  : v_hier_sched_if
// Purpose : Requester, shared-datapath and result signals of v_hier_sched.
// Rev     : 1.0
// ============================================================================
`default_nettype none

interface v_hier_sched_if;
  logic [3:0]  req;
  logic [15:0] req_a;
  logic [3:0]  gnt;
  logic [3:0]  avec;
  logic [3:0]  qvec;
  logic        res_valid;
  logic [1:0]  res_id;
  logic [3:0]  res_q;
  logic        busy;

  modport master (
    input  req, req_a, qvec,
    output gnt, avec, res_valid, res_id, res_q, busy
  );

  modport slave (
    output req, req_a, qvec,
    input  gnt, avec, res_valid, res_id, res_q, busy
  );
endinterface

`default_nettype wire

// File: rtl/v_hier_sched.sv
// ============================================================================
// Module  : v_hier_sched
// Purpose : Round-robin time-sharing of one v_hier_sub among 4 requesters.
// Rev     : 1.0
// ============================================================================
`default_nettype none

module v_hier_sched #(
  parameter int HOLD_CYCLES = 2
) (
  input  logic             clk,
  input  logic             reset,
  v_hier_sched_if.master   bus
);

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_DRIVE = 1'b1
  } state_t;

  localparam logic [3:0] c_hold_load = 4'(HOLD_CYCLES - 1);

  state_t     state_q, state_d;
  logic [1:0] ptr_q, ptr_d;
  logic [1:0] owner_q, owner_d;
  logic [3:0] cnt_q, cnt_d;
  logic [3:0] gnt_q, gnt_d;
  logic [3:0] avec_q, avec_d;
  logic       res_valid_q, res_valid_d;
  logic [1:0] res_id_q, res_id_d;
  logic [3:0] res_q_q, res_q_d;

  logic       arb_found;
  logic [1:0] arb_idx;

  // Search starts just above the last owner, so it ends up lowest priority.
  always_comb begin
    arb_found = 1'b0;
    arb_idx   = ptr_q;
    for (int k = 1; k <= 4; k++) begin
      if (!arb_found && bus.req[ptr_q + 2'(k)]) begin
        arb_found = 1'b1;
        arb_idx   = ptr_q + 2'(k);
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    owner_d     = owner_q;
    cnt_d       = cnt_q;
    gnt_d       = gnt_q;
    avec_d      = avec_q;
    res_valid_d = 1'b0;
    res_id_d    = res_id_q;
    res_q_d     = res_q_q;

    unique case (state_q)
      ST_IDLE: begin
        if (arb_found) begin
          state_d = ST_DRIVE;
          owner_d = arb_idx;
          cnt_d   = c_hold_load;
          gnt_d   = 4'b0001 << arb_idx;
          avec_d  = bus.req_a[{arb_idx, 2'b00} +: 4];
        end
      end
      ST_DRIVE: begin
        if (cnt_q == 4'd0) begin
          state_d     = ST_IDLE;
          ptr_d       = owner_q;
          gnt_d       = 4'b0000;
          avec_d      = 4'b0000;
          res_valid_d = 1'b1;
          res_id_d    = owner_q;
          res_q_d     = bus.qvec;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      ptr_q       <= 2'd3;
      owner_q     <= 2'd0;
      cnt_q       <= 4'd0;
      gnt_q       <= 4'b0000;
      avec_q      <= 4'b0000;
      res_valid_q <= 1'b0;
      res_id_q    <= 2'd0;
      res_q_q     <= 4'b0000;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      owner_q     <= owner_d;
      cnt_q       <= cnt_d;
      gnt_q       <= gnt_d;
      avec_q      <= avec_d;
      res_valid_q <= res_valid_d;
      res_id_q    <= res_id_d;
      res_q_q     <= res_q_d;
    end
  end

  assign bus.gnt       = gnt_q;
  assign bus.busy      = |gnt_q;
  assign bus.avec      = avec_q;
  assign bus.res_valid = res_valid_q;
  assign bus.res_id    = res_id_q;
  assign bus.res_q     = res_q_q;

endmodule

`default_nettype wire

// File: tb/tb_v_hier_sched.sv
// ============================================================================
// Module  : tb_v_hier_sched
// Purpose : Self-checking bench for v_hier_sched (HOLD_CYCLES 2 and 1 builds).
// Rev     : 1.0
// ============================================================================
`default_nettype none

module tb_v_hier_sched;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  v_hier_sched_if bus ();
  v_hier_sched_if bus1 ();

  // Stand-in for v_hier_sub: qvec[0]=1, qvec[2]=0, other bits follow avec.
  function automatic logic [3:0] sub_q(input logic [3:0] a);
    return {~a[3], 1'b0, a[1] ^ a[0], 1'b1};
  endfunction

  assign bus.qvec  = sub_q(bus.avec);
  assign bus1.qvec = sub_q(bus1.avec);

  v_hier_sched #(.HOLD_CYCLES(2)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  v_hier_sched #(.HOLD_CYCLES(1)) dut1 (
    .clk   (clk),
    .reset (reset),
    .bus   (bus1)
  );

  // Reference model of the HOLD_CYCLES=2 instance, transaction-level view.
  localparam int M_HOLD = 2;
  logic [3:0] m_gnt  = '0;
  logic [3:0] m_avec = '0;
  logic       m_rv   = 1'b0;
  logic [1:0] m_rid  = '0;
  logic [3:0] m_rq   = '0;
  int         m_ptr  = 3;
  int         m_left = 0;
  int         m_owner = 0;
  logic [3:0] m_opnd = '0;

  always @(posedge clk) begin
    if (reset) begin
      m_gnt = '0; m_avec = '0; m_rv = 1'b0; m_rid = '0; m_rq = '0;
      m_ptr = 3; m_left = 0;
    end else begin
      m_rv = 1'b0;
      if (m_left > 0) begin
        if (m_left == 1) begin
          m_rq   = sub_q(m_opnd);
          m_rid  = 2'(m_owner);
          m_rv   = 1'b1;
          m_ptr  = m_owner;
          m_left = 0;
          m_gnt  = '0;
          m_avec = '0;
        end else begin
          m_left = m_left - 1;
        end
      end else if (bus.req != 4'b0000) begin
        for (int k = 1; k <= 4; k++) begin
          int w;
          w = (m_ptr + k) % 4;
          if (m_left == 0 && bus.req[w]) begin
            m_owner = w;
            m_opnd  = bus.req_a[4*w +: 4];
            m_left  = M_HOLD;
            m_gnt   = 4'(1 << w);
            m_avec  = m_opnd;
          end
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    bus.req = '0;  bus.req_a = '0;
    bus1.req = '0; bus1.req_a = '0;
    step();
    step();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    bus.req = 4'b1111;
    bus.req_a = 16'hFFFF;
    step();
    step();
    checks++;
    if ({bus.gnt, bus.avec, bus.busy, bus.res_valid, bus.res_id, bus.res_q} !== 16'h0) begin
      errors++;
      $display("FAIL reset_outputs: got gnt=%b avec=%h busy=%b rv=%b id=%0d q=%h expected all 0",
               bus.gnt, bus.avec, bus.busy, bus.res_valid, bus.res_id, bus.res_q);
    end
    bus.req = '0;
    reset = 1'b0;
    step();
    checks++;
    if (bus.gnt !== 4'b0000 || bus.res_valid !== 1'b0) begin
      errors++;
      $display("FAIL idle_no_req: got gnt=%b rv=%b expected 0000/0", bus.gnt, bus.res_valid);
    end
  endtask

  task automatic test_single();
    do_reset();
    bus.req = 4'b0001;
    bus.req_a = 16'h000A;
    step();
    bus.req = 4'b0000;
    bus.req_a = 16'h0005;
    for (int c = 1; c <= 2; c++) begin
      checks++;
      if (bus.gnt !== 4'b0001 || bus.avec !== 4'hA || bus.busy !== 1'b1 || bus.res_valid !== 1'b0) begin
        errors++;
        $display("FAIL single_drive c%0d: got gnt=%b avec=%h busy=%b rv=%b expected 0001/a/1/0",
                 c, bus.gnt, bus.avec, bus.busy, bus.res_valid);
      end
      step();
    end
    checks++;
    if (bus.res_valid !== 1'b1 || bus.res_id !== 2'd0 || bus.res_q !== 4'b0011 ||
        bus.gnt !== 4'b0000 || bus.busy !== 1'b0 || bus.avec !== 4'h0) begin
      errors++;
      $display("FAIL single_result: got rv=%b id=%0d q=%b gnt=%b busy=%b avec=%h expected 1/0/0011/0000/0/0",
               bus.res_valid, bus.res_id, bus.res_q, bus.gnt, bus.busy, bus.avec);
    end
    step();
    checks++;
    if (bus.res_valid !== 1'b0 || bus.res_q !== 4'b0011 || bus.res_id !== 2'd0) begin
      errors++;
      $display("FAIL single_hold: got rv=%b q=%b id=%0d expected 0/0011/0",
               bus.res_valid, bus.res_q, bus.res_id);
    end
  endtask

  task automatic test_round_robin();
    logic [15:0] ops;
    do_reset();
    ops = 16'h7C39;
    bus.req = 4'b1111;
    bus.req_a = ops;
    for (int c = 1; c <= 15; c++) begin
      int phase;
      int who;
      logic [3:0] exp_gnt;
      step();
      phase = (c - 1) % 3;
      who = ((c - 1) / 3) % 4;
      exp_gnt = (phase < 2) ? 4'(1 << who) : 4'b0000;
      checks++;
      if (bus.gnt !== exp_gnt || bus.res_valid !== (phase == 2) ||
          (phase < 2 && bus.avec !== ops[4*who +: 4]) ||
          (phase == 2 && bus.res_id !== 2'(who))) begin
        errors++;
        $display("FAIL rr_order c%0d: got gnt=%b rv=%b id=%0d avec=%h expected gnt=%b rv=%0d id=%0d",
                 c, bus.gnt, bus.res_valid, bus.res_id, bus.avec, exp_gnt, phase == 2, who);
      end
    end
    bus.req = '0;
  endtask

  task automatic test_pulse();
    do_reset();
    bus.req = 4'b0100;
    bus.req_a = 16'h0600;
    step();
    bus.req = 4'b0000;
    bus.req_a = 16'h0000;
    step();
    checks++;
    if (bus.gnt !== 4'b0100 || bus.avec !== 4'h6) begin
      errors++;
      $display("FAIL pulse_drive: got gnt=%b avec=%h expected 0100/6", bus.gnt, bus.avec);
    end
    step();
    checks++;
    if (bus.res_valid !== 1'b1 || bus.res_id !== 2'd2 || bus.res_q !== sub_q(4'h6)) begin
      errors++;
      $display("FAIL pulse_result: got rv=%b id=%0d q=%b expected 1/2/%b",
               bus.res_valid, bus.res_id, bus.res_q, sub_q(4'h6));
    end
  endtask

  task automatic test_reset_mid_drive();
    int rv_seen;
    do_reset();
    bus.req = 4'b0001;
    bus.req_a = 16'h0003;
    step();
    bus.req = 4'b0000;
    step();
    reset = 1'b1;
    step();
    reset = 1'b0;
    checks++;
    if ({bus.gnt, bus.avec, bus.busy, bus.res_valid, bus.res_id, bus.res_q} !== 16'h0) begin
      errors++;
      $display("FAIL abort_outputs: got gnt=%b avec=%h busy=%b rv=%b id=%0d q=%h expected all 0",
               bus.gnt, bus.avec, bus.busy, bus.res_valid, bus.res_id, bus.res_q);
    end
    rv_seen = 0;
    for (int c = 0; c < 4; c++) begin
      step();
      if (bus.res_valid === 1'b1) rv_seen++;
    end
    checks++;
    if (rv_seen != 0) begin
      errors++;
      $display("FAIL abort_no_result: got %0d strobes expected 0", rv_seen);
    end
    bus.req = 4'b0010;
    bus.req_a = 16'h00E0;
    step();
    bus.req = 4'b0000;
    checks++;
    if (bus.gnt !== 4'b0010 || bus.avec !== 4'hE) begin
      errors++;
      $display("FAIL abort_regrant: got gnt=%b avec=%h expected 0010/e", bus.gnt, bus.avec);
    end
    step();
    step();
  endtask

  task automatic test_priority();
    do_reset();
    bus.req = 4'b0001;
    bus.req_a = 16'h0001;
    step();
    bus.req = 4'b0000;
    step();
    step();
    bus.req = 4'b1001;
    bus.req_a = 16'h9002;
    step();
    checks++;
    if (bus.gnt !== 4'b1000 || bus.avec !== 4'h9) begin
      errors++;
      $display("FAIL prio_after_0: got gnt=%b avec=%h expected 1000/9", bus.gnt, bus.avec);
    end
    step();
    step();
    checks++;
    if (bus.res_valid !== 1'b1 || bus.res_id !== 2'd3) begin
      errors++;
      $display("FAIL prio_result3: got rv=%b id=%0d expected 1/3", bus.res_valid, bus.res_id);
    end
    step();
    checks++;
    if (bus.gnt !== 4'b0001) begin
      errors++;
      $display("FAIL prio_then_0: got gnt=%b expected 0001", bus.gnt);
    end
    bus.req = 4'b0000;
    step();
    step();
  endtask

  task automatic test_hold1();
    do_reset();
    bus1.req = 4'b0001;
    bus1.req_a = 16'h0004;
    step();
    bus1.req = 4'b0000;
    checks++;
    if (bus1.gnt !== 4'b0001 || bus1.avec !== 4'h4 || bus1.res_valid !== 1'b0) begin
      errors++;
      $display("FAIL hold1_drive: got gnt=%b avec=%h rv=%b expected 0001/4/0",
               bus1.gnt, bus1.avec, bus1.res_valid);
    end
    step();
    checks++;
    if (bus1.gnt !== 4'b0000 || bus1.res_valid !== 1'b1 || bus1.res_id !== 2'd0 ||
        bus1.res_q !== sub_q(4'h4)) begin
      errors++;
      $display("FAIL hold1_result: got gnt=%b rv=%b id=%0d q=%b expected 0000/1/0/%b",
               bus1.gnt, bus1.res_valid, bus1.res_id, bus1.res_q, sub_q(4'h4));
    end
    step();
    checks++;
    if (bus1.res_valid !== 1'b0) begin
      errors++;
      $display("FAIL hold1_one_strobe: got rv=%b expected 0", bus1.res_valid);
    end
  endtask

  task automatic test_random();
    do_reset();
    for (int c = 0; c < 400; c++) begin
      reset = ($urandom_range(0, 59) == 0);
      bus.req = ($urandom_range(0, 2) == 0) ? 4'b0000 : 4'($urandom);
      bus.req_a = 16'($urandom);
      step();
      checks++;
      if (bus.gnt !== m_gnt || bus.avec !== m_avec || bus.busy !== (|m_gnt) ||
          bus.res_valid !== m_rv || bus.res_id !== m_rid || bus.res_q !== m_rq) begin
        errors++;
        $display("FAIL rand_model c%0d: got gnt=%b avec=%h busy=%b rv=%b id=%0d q=%h expected gnt=%b avec=%h busy=%b rv=%b id=%0d q=%h",
                 c, bus.gnt, bus.avec, bus.busy, bus.res_valid, bus.res_id, bus.res_q,
                 m_gnt, m_avec, |m_gnt, m_rv, m_rid, m_rq);
      end
      checks++;
      if ($countones(bus.gnt) > 1) begin
        errors++;
        $display("FAIL rand_onehot c%0d: got gnt=%b expected at most one bit", c, bus.gnt);
      end
    end
    reset = 1'b0;
    bus.req = '0;
  endtask

  initial begin
    bus.req = '0;  bus.req_a = '0;
    bus1.req = '0; bus1.req_a = '0;
    test_reset();
    test_single();
    test_round_robin();
    test_pulse();
    test_reset_mid_drive();
    test_priority();
    test_hold1();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/v_hier_sched.md
V_HIER_SCHED -- requirements
Module: v_hier_sched

Interface
REQ-001 Parameter HOLD_CYCLES, default 2, SHALL set the number of cycles avec is held before qvec is sampled, with a legal range of 1..15.
REQ-002 clk  input  1  SHALL be the single clock, with all state updating on the rising edge.
REQ-003 reset  input  1  SHALL be a synchronous, active-high reset sampled on the rising edge of clk.
REQ-004 req  input  4  SHALL carry the per-requester request levels, with bit i belonging to requester i.
REQ-005 req_a  input  16  SHALL carry the per-requester operands, with requester i at bits [4i+3:4i].
REQ-006 gnt  output  4  SHALL be the one-hot grant, registered and high throughout the owner's transaction.
REQ-007 avec  output  4  SHALL drive the shared v_hier_sub avec input.
REQ-008 qvec  input  4  SHALL receive the shared v_hier_sub qvec output.
REQ-009 res_valid  output  1  SHALL be a one-cycle result strobe.
REQ-010 res_id  output  2  SHALL carry the index of the requester owning the result.
REQ-011 res_q  output  4  SHALL carry the sampled qvec value.
REQ-012 busy  output  1  SHALL be high while a transaction occupies the datapath.

Function
REQ-013 The block SHALL time-share one v_hier_sub instance among 4 requesters using a round-robin arbiter and a 2-state FSM (IDLE, DRIVE).
REQ-014 In IDLE with any req bit high in cycle N, the block SHALL select the first requesting index searching upward from ptr+1 modulo 4.
REQ-015 In cycle N+1 after that selection, gnt SHALL be one-hot on the winner, busy SHALL be 1, avec SHALL equal the winner's req_a slice, and the state SHALL be DRIVE.
REQ-016 The winner's operand SHALL be captured at the grant edge, so that req_a changes during DRIVE do not affect avec.
REQ-017 DRIVE SHALL last exactly HOLD_CYCLES cycles (N+1..N+HOLD_CYCLES), timed by a 4-bit down-counter loaded with HOLD_CYCLES-1.
REQ-018 On the last DRIVE cycle, qvec SHALL be registered into res_q and the winner index into res_id.
REQ-019 In cycle N+HOLD_CYCLES+1, res_valid SHALL be 1, gnt SHALL be 0, busy SHALL be 0, avec SHALL be 0, ptr SHALL equal the winner index, and the state SHALL be IDLE.
REQ-020 res_valid SHALL be high for exactly one cycle per transaction.
REQ-021 res_q and res_id SHALL hold their values until the next result.
REQ-022 Back-to-back operation: the IDLE cycle that carries res_valid SHALL also arbitrate, giving a minimum transaction spacing of HOLD_CYCLES+1 cycles.
REQ-023 Deassertion of req during DRIVE SHALL NOT abort the transaction, which completes and produces res_valid.
REQ-024 A requester still asserting req after its own result SHALL have lowest priority in the next arbitration.
REQ-025 With no req bits high in IDLE, all outputs except res_q and res_id SHALL remain 0, and ptr SHALL be unchanged.
REQ-026 gnt SHALL never have more than one bit set.
REQ-027 busy SHALL equal the OR of the gnt bits.
REQ-028 HOLD_CYCLES=1 SHALL give a DRIVE phase of one cycle, with qvec sampled in that same cycle.

Reset
REQ-029 On reset, the state SHALL become IDLE and gnt, avec, busy, res_valid, res_q and res_id SHALL all become 0.
REQ-030 On reset, ptr SHALL become 3, so that requester 0 has highest priority first.
REQ-031 Reset asserted mid-DRIVE SHALL abandon the transaction, producing no res_valid, and the outputs SHALL take their reset values on the next cycle.
REQ-032 reset SHALL take precedence over all other inputs in the same cycle.

Verification (HOLD_CYCLES=2, sub model: qvec[0]=1, qvec[2]=0)
REQ-033 Reset, then req=0001 with req_a[3:0]=4'hA at cycle 0 -> gnt=0001, avec=4'hA, busy=1 in cycles 1-2; res_valid=1, res_id=0, res_q matching the model in cycle 3; gnt=0 in cycle 3.
REQ-034 req=1111 held constant -> grant order 0,1,2,3,0, each grant separated by 3 cycles, with no idle gap between a res_valid cycle and the next arbitration.
REQ-035 req=0100 pulsed for one cycle only -> transaction still completes, with res_id=2 three cycles later.
REQ-036 reset asserted in cycle 2 of a DRIVE -> no res_valid is ever produced; in the following cycle all outputs are 0 and the next req=0010 is granted normally.
REQ-037 req=1001 with ptr=0 after a requester-0 result -> requester 3 is granted before requester 0.
REQ-038 HOLD_CYCLES=1 build with req=0001 -> gnt in cycle 1 only, res_valid in cycle 2.
